// File: rtl/vcve2_vrf_mem.sv
// Word-organised VRF storage acting as responder on the data_req/gnt/rvalid bus.
// Grants after GntDelay cycles, byte-enabled writes, one-cycle responses, zero-clear sequence.
module vcve2_vrf_mem #(
  parameter int unsigned VLEN      = 128,
  parameter int unsigned NumVRegs  = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned GntDelay  = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 data_req_i,
  output logic                 data_gnt_o,
  output logic                 data_rvalid_o,
  output logic                 data_err_o,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [31:0]          data_addr_i,
  input  logic [DataWidth-1:0] data_wdata_i,
  output logic [DataWidth-1:0] data_rdata_o,
  input  logic                 init_req_i,
  output logic                 init_busy_o
);

  localparam int unsigned Depth    = NumVRegs * VLEN / DataWidth;
  localparam int unsigned IdxW     = $clog2(Depth);
  localparam int unsigned NumBytes = DataWidth / 8;
  localparam logic [3:0]  CntLoad  = (GntDelay > 0) ? 4'(GntDelay - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_INIT
  } state_e;

  state_e               r_state;
  logic [3:0]           r_cnt;
  logic [IdxW-1:0]      r_clr_idx;
  logic                 r_busy;
  logic                 r_rvalid;
  logic                 r_err;
  logic [DataWidth-1:0] r_rdata;
  logic [DataWidth-1:0] r_mem [Depth];

  logic                 w_gnt;
  logic                 w_bad;
  logic [IdxW-1:0]      w_idx;

  assign w_idx = data_addr_i[IdxW+1:2];
  assign w_bad = (data_addr_i[1:0] != 2'b00) || (data_addr_i[31:2] >= 30'(Depth));

  // Grant is combinational so a zero-delay request completes in its own cycle.
  always_comb begin
    w_gnt = 1'b0;
    case (r_state)
      S_IDLE:  w_gnt = data_req_i && !init_req_i && (GntDelay == 0);
      S_WAIT:  w_gnt = data_req_i && (r_cnt == '0);
      default: w_gnt = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_clr_idx <= '0;
      r_busy    <= 1'b0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rvalid <= w_gnt;
      // Response fields only change on grant, so they hold while rvalid is low.
      if (w_gnt) begin
        r_err   <= w_bad;
        r_rdata <= (w_bad || data_we_i) ? '0 : r_mem[w_idx];
      end
      case (r_state)
        S_IDLE: begin
          if (init_req_i) begin
            r_state   <= S_INIT;
            r_clr_idx <= '0;
            r_busy    <= 1'b1;
          end else if (data_req_i && (GntDelay != 0)) begin
            r_state <= S_WAIT;
            r_cnt   <= CntLoad;
          end
        end
        S_WAIT: begin
          if (!data_req_i || (r_cnt == '0)) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_INIT: begin
          r_clr_idx <= r_clr_idx + 1'b1;
          if (r_clr_idx == IdxW'(Depth - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (r_state == S_INIT) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_gnt && data_we_i && !w_bad) begin
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (data_be_i[b]) begin
          r_mem[w_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign data_gnt_o    = w_gnt;
  assign data_rvalid_o = r_rvalid;
  assign data_err_o    = r_err;
  assign data_rdata_o  = r_rdata;
  assign init_busy_o   = r_busy;

endmodule

// File: tb/tb_vcve2_vrf_mem.sv
// Randomized bench for vcve2_vrf_mem: one instance with GntDelay=0 and one with GntDelay=3,
// both checked against a word-array model of the storage and response rules.
module tb_vcve2_vrf_mem;

  logic        clk;
  logic        rst_n;
  logic        req    [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic        err    [2];
  logic        we_s   [2];
  logic [3:0]  be_s   [2];
  logic [31:0] addr_s [2];
  logic [31:0] wd_s   [2];
  logic [31:0] rdata  [2];
  logic        init_s [2];
  logic        busy   [2];

  logic [31:0] mdl     [2][128];
  logic [31:0] last_rd [2];
  logic        last_err[2];

  int unsigned n_vec;
  int unsigned n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vcve2_vrf_mem #(.GntDelay(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .data_req_i(req[0]), .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid[0]), .data_err_o(err[0]),
    .data_we_i(we_s[0]), .data_be_i(be_s[0]), .data_addr_i(addr_s[0]), .data_wdata_i(wd_s[0]),
    .data_rdata_o(rdata[0]), .init_req_i(init_s[0]), .init_busy_o(busy[0])
  );

  vcve2_vrf_mem #(.GntDelay(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .data_req_i(req[1]), .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid[1]), .data_err_o(err[1]),
    .data_we_i(we_s[1]), .data_be_i(be_s[1]), .data_addr_i(addr_s[1]), .data_wdata_i(wd_s[1]),
    .data_rdata_o(rdata[1]), .init_req_i(init_s[1]), .init_busy_o(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that delivers the response.
  task automatic txn(input int d, input logic we, input logic [31:0] a,
                     input logic [3:0] be, input logic [31:0] wd);
    logic        bad;
    logic [31:0] exp_rd;
    int unsigned idx;
    int unsigned lat;
    bad    = (a[1:0] != 2'b00) || (a[31:2] >= 30'd128);
    idx    = a[8:2];
    exp_rd = (bad || we) ? 32'h0 : mdl[d][idx];
    we_s[d] = we; addr_s[d] = a; be_s[d] = be; wd_s[d] = wd; req[d] = 1'b1;
    lat = 0;
    #4;
    while (!gnt[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      #4;
    end
    check($sformatf("gnt_lat%0d", d), lat, (d == 0) ? 0 : 3);
    @(posedge clk); #1;
    req[d] = 1'b0;
    check($sformatf("rvalid%0d", d), {31'b0, rvalid[d]}, 32'd1);
    check($sformatf("err%0d", d), {31'b0, err[d]}, {31'b0, bad});
    check($sformatf("rdata%0d@%08h", d, a), rdata[d], exp_rd);
    last_rd[d]  = exp_rd;
    last_err[d] = bad;
    if (we && !bad) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  task automatic idle_hold(input int d);
    @(posedge clk); #1;
    check($sformatf("hold_rvalid%0d", d), {31'b0, rvalid[d]}, 32'd0);
    check($sformatf("hold_rdata%0d", d), rdata[d], last_rd[d]);
    check($sformatf("hold_err%0d", d), {31'b0, err[d]}, {31'b0, last_err[d]});
  endtask

  function automatic logic [31:0] rand_addr(input int d);
    int unsigned r;
    logic [31:0] a;
    r = $urandom_range(0, 9);
    if (r == 0) begin
      a = ($urandom_range(0, 127) << 2) | $urandom_range(1, 3);
    end else if (r == 1) begin
      a = $urandom & 32'hFFFF_FFFC;
      if (a < 32'h200) a = a | 32'h200;
    end else begin
      a = $urandom_range(0, (d == 0) ? 127 : 7) << 2;
    end
    return a;
  endfunction

  initial begin
    int unsigned cnt;
    logic        gnt_seen;
    n_vec = 0; n_fail = 0;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we_s[d] = 1'b0; be_s[d] = '0; addr_s[d] = '0; wd_s[d] = '0; init_s[d] = 1'b0;
      last_rd[d] = '0; last_err[d] = 1'b0;
      for (int i = 0; i < 128; i++) mdl[d][i] = 'x;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_gnt", {31'b0, gnt[d]}, 32'd0);
      check("rst_rvalid", {31'b0, rvalid[d]}, 32'd0);
      check("rst_err", {31'b0, err[d]}, 32'd0);
      check("rst_rdata", rdata[d], 32'd0);
      check("rst_busy", {31'b0, busy[d]}, 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Put a non-zero word at 127, then start init together with a read of it.
    txn(0, 1'b1, 32'h1FC, 4'hF, 32'hCAFEF00D);
    init_s[0] = 1'b1; req[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 32'h1FC;
    #4;
    check("init_prio_gnt", {31'b0, gnt[0]}, 32'd0);
    @(posedge clk); #1;
    init_s[0] = 1'b0;
    cnt = 0; gnt_seen = 1'b0;
    while (busy[0] && cnt < 300) begin
      if (gnt[0]) gnt_seen = 1'b1;
      cnt++;
      @(posedge clk); #1;
    end
    check("init_cycles", cnt, 32'd128);
    check("init_nogrant", {31'b0, gnt_seen}, 32'd0);
    for (int i = 0; i < 128; i++) mdl[0][i] = 32'h0;
    #4;
    check("post_init_gnt", {31'b0, gnt[0]}, 32'd1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    check("post_init_rvalid", {31'b0, rvalid[0]}, 32'd1);
    check("post_init_rdata", rdata[0], 32'd0);
    last_rd[0] = 32'h0; last_err[0] = 1'b0;

    txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    txn(0, 1'b0, 32'h10, 4'h0, 32'h0);
    idle_hold(0);
    txn(0, 1'b1, 32'h10, 4'b0101, 32'h11223344);
    txn(0, 1'b0, 32'h10, 4'h0, 32'h0);
    check("partial_word", rdata[0], 32'hDE22BE44);
    txn(0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF);
    txn(0, 1'b0, 32'h202, 4'h0, 32'h0);
    txn(0, 1'b0, 32'h200, 4'h0, 32'h0);
    txn(0, 1'b1, 32'h200, 4'hF, 32'h55555555);
    txn(0, 1'b1, 32'h012, 4'hF, 32'h66666666);
    txn(0, 1'b0, 32'h10, 4'h0, 32'h0);

    for (int n = 0; n < 300; n++) begin
      txn(0, 1'($urandom_range(0, 1)), rand_addr(0), 4'($urandom), $urandom);
      if ($urandom_range(0, 7) == 0) idle_hold(0);
    end

    for (int i = 0; i < 8; i++) txn(1, 1'b1, 32'(i * 4), 4'hF, $urandom);
    // A request withdrawn while waiting must never be granted or answered.
    req[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 32'h0;
    @(posedge clk); #1;
    req[1] = 1'b0;
    gnt_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #4;
      if (gnt[1] || rvalid[1]) gnt_seen = 1'b1;
      @(posedge clk); #1;
    end
    check("abort_no_resp", {31'b0, gnt_seen}, 32'd0);
    for (int n = 0; n < 60; n++) begin
      txn(1, 1'($urandom_range(0, 1)), rand_addr(1), 4'($urandom), $urandom);
      if ($urandom_range(0, 5) == 0) idle_hold(1);
    end

    // Reset between grant and response: the response must be dropped.
    req[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 32'h10;
    #4;
    check("pre_rst_gnt", {31'b0, gnt[0]}, 32'd1);
    rst_n = 1'b0; req[0] = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_rvalid", {31'b0, rvalid[0]}, 32'd0);
    check("mid_rst_rdata", rdata[0], 32'd0);
    check("mid_rst_err", {31'b0, err[0]}, 32'd0);
    check("mid_rst_busy", {31'b0, busy[0]}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_rvalid", {31'b0, rvalid[0]}, 32'd0);
    txn(0, 1'b1, 32'h40, 4'hF, 32'h0BADF00D);
    txn(0, 1'b0, 32'h40, 4'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
